ace_mem_slave: RTL

- Downstream memory endpoint for the LSU's ACE master port.
- Accepts AXI-subset read (AR/R) and write (AW/W/B) bursts and services them from an internal byte-strobed single-port RAM.
- Snoop channels (AC/CR/CD) and rack/wack are outside this block; the top level ties them off.
- Used as the memory model in LSU-level benches and as an on-chip scratch memory.

---
 rtl/ace_mem_slave.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ace_mem_slave.sv
// ace_mem_slave: AXI-subset memory endpoint behind the LSU ACE master port.
// It services INCR read bursts (AR/R) and write bursts (AW/W/B) from an
// internal byte-strobed single-port RAM, with one transaction in flight.
// Snoop channels and rack/wack are tied off by the parent.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   aw* / w* / b*            write address, data and response channels
//   ar* / r*                 read address and data channels
//
// Optional build macro ACE_MEM_SLAVE_ERR_EN: beats outside
// [BASE_ADDR, BASE_ADDR + depth*bytes) are not written, read as 0 and
// return SLVERR. Without it addresses wrap modulo depth and all responses
// are OKAY.
module ace_mem_slave #(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_DEPTH_LOG2   = 10,
  parameter int ACE_XID_WIDTH    = 4,
  parameter int ACE_AXADDR_WIDTH = 32,
  parameter int ACE_AXLEN_WIDTH  = 8,
  parameter int ACE_BRESP_WIDTH  = 2,
  parameter int ACE_RRESP_WIDTH  = 2,
  parameter logic [ACE_AXADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ACE_XID_WIDTH-1:0]    awid,
  input  logic [ACE_AXADDR_WIDTH-1:0] awaddr,
  input  logic [ACE_AXLEN_WIDTH-1:0]  awlen,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [ACE_XID_WIDTH-1:0]    bid,
  output logic [ACE_BRESP_WIDTH-1:0]  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [ACE_XID_WIDTH-1:0]    arid,
  input  logic [ACE_AXADDR_WIDTH-1:0] araddr,
  input  logic [ACE_AXLEN_WIDTH-1:0]  arlen,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [ACE_XID_WIDTH-1:0]    rid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [ACE_RRESP_WIDTH-1:0]  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_BRSP = 2'd3;

  typedef struct packed {
    logic                  last;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rbeat_t;

  logic [1:0]                  state;
  logic                        last_rd;   // 1: previous grant was a read
  logic [ACE_XID_WIDTH-1:0]    id_q;
  logic [ACE_AXADDR_WIDTH-1:0] addr_q;    // byte address of current beat
  logic [ACE_AXLEN_WIDTH-1:0]  len_q;
  logic [ACE_AXLEN_WIDTH-1:0]  beat_cnt;  // beats issued (RD) / accepted (WR)
  logic                        iss_done;
  logic                        wr_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Beat address decode, shared by both directions (one burst at a time).
  logic [ACE_AXADDR_WIDTH-1:0] addr_off;
  logic [MEM_DEPTH_LOG2-1:0]   idx;
  logic                        oor;
  logic                        beat_err;

  assign addr_off = addr_q - BASE_ADDR;
  assign idx      = addr_off[LSB +: MEM_DEPTH_LOG2];
  // Below-base addresses wrap to huge offsets, so one compare covers both ends.
  assign oor      = |(addr_off >> (LSB + MEM_DEPTH_LOG2));

`ifdef ACE_MEM_SLAVE_ERR_EN
  assign beat_err = oor;
`else
  assign beat_err = 1'b0;
`endif

  // wlast is deliberately ignored: the beat counter ends the burst.
  logic unused_ok;
  assign unused_ok = ^{wlast, addr_off, oor};

  // Arbitration: a lone request wins; on contention alternate sides.
  logic grant_rd, grant_wr;
  assign grant_rd = arvalid && (!awvalid || !last_rd);
  assign grant_wr = awvalid && !grant_rd;

  assign arready = rst && (state == S_IDLE) && grant_rd;
  assign awready = rst && (state == S_IDLE) && grant_wr;
  assign wready  = (state == S_WR);
  assign bvalid  = (state == S_BRSP);
  assign bid     = id_q;
  assign bresp   = wr_err ? ACE_BRESP_WIDTH'(2) : '0;

  logic ar_hs, aw_hs, w_hs;
  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Read path: RAM output register followed by a 2-entry skid buffer. The
  // RAM register cannot stall, so a beat it holds that is not taken this
  // cycle is moved into the skid buffer.
  logic [DATA_WIDTH-1:0] ram_rd;
  logic                  ram_vld, ram_last, ram_err;
  rbeat_t                ram_beat, head;
  rbeat_t [1:0]          fifo, fifo_n;
  logic [1:0]            fcnt, fcnt_n;
  logic                  pop, issue;

  assign ram_beat = '{last: ram_last, err: ram_err,
                      data: (ram_err || !ram_vld) ? '0 : ram_rd};
  assign head     = (fcnt != 2'd0) ? fifo[0] : ram_beat;

  assign rvalid = (fcnt != 2'd0) || ram_vld;
  assign rdata  = head.data;
  assign rlast  = head.last;
  assign rresp  = head.err ? ACE_RRESP_WIDTH'(2) : '0;
  assign rid    = id_q;
  assign pop    = rvalid && rready;

  always_comb begin
    fifo_n = fifo;
    fcnt_n = fcnt + 2'(ram_vld) - 2'(pop);
    if (pop) begin
      fifo_n[0] = (fcnt == 2'd2) ? fifo[1] : ram_beat;
      fifo_n[1] = ram_beat;
    end else begin
      fifo_n[0] = (fcnt != 2'd0) ? fifo[0] : ram_beat;
      fifo_n[1] = (fcnt == 2'd2) ? fifo[1] : ram_beat;
    end
  end

  // Issue only if the skid buffer can absorb the new beat plus everything
  // still queued, assuming the consumer stalls from now on.
  assign issue = (state == S_RD) && !iss_done && (fcnt_n <= 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo     <= '0;
      fcnt     <= '0;
      ram_vld  <= 1'b0;
      ram_last <= 1'b0;
      ram_err  <= 1'b0;
    end else begin
      fifo    <= fifo_n;
      fcnt    <= fcnt_n;
      ram_vld <= issue;
      if (issue) begin
        ram_last <= (beat_cnt == len_q);
        ram_err  <= beat_err;
      end
    end
  end

  // Single-port RAM: reads only in RD, writes only in WR.
  always_ff @(posedge clk) begin
    if (w_hs && !beat_err)
      for (int b = 0; b < BYTES; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    if (issue) ram_rd <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      last_rd  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      iss_done <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ar_hs) begin
            id_q     <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            beat_cnt <= '0;
            iss_done <= 1'b0;
            last_rd  <= 1'b1;
            state    <= S_RD;
          end else if (aw_hs) begin
            id_q     <= awid;
            addr_q   <= awaddr;
            len_q    <= awlen;
            beat_cnt <= '0;
            wr_err   <= 1'b0;
            last_rd  <= 1'b0;
            state    <= S_WR;
          end
        end
        S_RD: begin
          if (issue) begin
            addr_q   <= addr_q + ACE_AXADDR_WIDTH'(BYTES);
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == len_q) iss_done <= 1'b1;
          end
          if (pop && head.last) state <= S_IDLE;
        end
        S_WR: begin
          if (w_hs) begin
            addr_q   <= addr_q + ACE_AXADDR_WIDTH'(BYTES);
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_err) wr_err <= 1'b1;
            if (beat_cnt == len_q) state <= S_BRSP;
          end
        end
        default: begin
          if (bready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
